// File: rtl/lsu_addr_queue_if.sv
// AGU-side enqueue, data-cache request/response and ROB writeback signals of the
// load/store address queue.
interface lsu_addr_queue_if;
  logic        agu_valid;
  logic        agu_ready;
  logic [31:0] agu_addr;
  logic        agu_is_store;
  logic [1:0]  agu_size;
  logic        agu_unsigned;
  logic [31:0] agu_wdata;
  logic [5:0]  agu_rob_tag;

  logic        flush;

  logic        dc_req_valid;
  logic        dc_req_ready;
  logic [31:0] dc_req_addr;
  logic        dc_req_we;
  logic [3:0]  dc_req_be;
  logic [31:0] dc_req_wdata;

  logic        dc_resp_valid;
  logic [31:0] dc_resp_rdata;

  logic        wb_valid;
  logic [5:0]  wb_rob_tag;
  logic [31:0] wb_data;
  logic        wb_exc;

  // The queue itself.
  modport master (
    input  agu_valid, agu_addr, agu_is_store, agu_size, agu_unsigned,
           agu_wdata, agu_rob_tag, flush, dc_req_ready, dc_resp_valid,
           dc_resp_rdata,
    output agu_ready, dc_req_valid, dc_req_addr, dc_req_we, dc_req_be,
           dc_req_wdata, wb_valid, wb_rob_tag, wb_data, wb_exc
  );

  // The surrounding pipeline, cache and ROB.
  modport slave (
    output agu_valid, agu_addr, agu_is_store, agu_size, agu_unsigned,
           agu_wdata, agu_rob_tag, flush, dc_req_ready, dc_resp_valid,
           dc_resp_rdata,
    input  agu_ready, dc_req_valid, dc_req_addr, dc_req_we, dc_req_be,
           dc_req_wdata, wb_valid, wb_rob_tag, wb_data, wb_exc
  );
endinterface

// File: rtl/lsu_addr_queue.sv
// In-order load/store address queue: one op at a time goes to the data cache,
// misaligned or illegal-size ops complete with an exception and no cache access.
module lsu_addr_queue #(
  parameter int unsigned DEPTH = 4
) (
  input logic              clk,
  input logic              rst,
  lsu_addr_queue_if.master bus
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, EXC} state_e;

  state_e           state_q, state_d;
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             kill_q, kill_d;

  logic [31:0] addr_q   [DEPTH];
  logic        store_q  [DEPTH];
  logic [1:0]  size_q   [DEPTH];
  logic        uns_q    [DEPTH];
  logic [31:0] wdata_q  [DEPTH];
  logic [5:0]  tag_q    [DEPTH];

  logic [31:0] h_addr;
  logic        h_store;
  logic [1:0]  h_size;
  logic        h_uns;
  logic [31:0] h_wdata;
  logic [5:0]  h_tag;
  logic [1:0]  h_off;
  logic        h_mis;

  logic        enq, deq;
  logic        req_valid, wb_valid, wb_exc;
  logic [31:0] shifted, load_data;
  logic [3:0]  be;

  // ---------------------------------------------------------------- head entry
  always_comb begin
    h_addr  = addr_q[head_q];
    h_store = store_q[head_q];
    h_size  = size_q[head_q];
    h_uns   = uns_q[head_q];
    h_wdata = wdata_q[head_q];
    h_tag   = tag_q[head_q];
    h_off   = h_addr[1:0];
    h_mis   = (h_size == 2'd3)
           || ((h_size == 2'd1) && h_off[0])
           || ((h_size == 2'd2) && (h_off != 2'b00));
  end

  // ---------------------------------------------------------------- queue
  assign bus.agu_ready = (count_q < CNT_MAX);
  assign enq = bus.agu_valid && bus.agu_ready && !bus.flush;
  assign deq = ((state_q == WAIT) && bus.dc_resp_valid) || (state_q == EXC);

  always_ff @(posedge clk) begin
    if (enq) begin
      addr_q[tail_q]  <= bus.agu_addr;
      store_q[tail_q] <= bus.agu_is_store;
      size_q[tail_q]  <= bus.agu_size;
      uns_q[tail_q]   <= bus.agu_unsigned;
      wdata_q[tail_q] <= bus.agu_wdata;
      tag_q[tail_q]   <= bus.agu_rob_tag;
    end
  end

  // A flush while waiting on the cache keeps only the in-flight head so its
  // response can still be consumed; every other flush empties the queue.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (bus.flush) begin
      if ((state_q == WAIT) && !bus.dc_resp_valid) begin
        tail_d  = head_q + PTR_ONE;
        count_d = CNT_ONE;
      end else begin
        head_d  = '0;
        tail_d  = '0;
        count_d = '0;
      end
    end else begin
      if (enq) tail_d = tail_q + PTR_ONE;
      if (deq) head_d = head_q + PTR_ONE;
      case ({enq, deq})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  always_comb begin
    kill_d = 1'b0;
    if (state_q == WAIT) begin
      kill_d = kill_q;
      if (bus.dc_resp_valid) kill_d = 1'b0;
      else if (bus.flush)    kill_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      kill_q  <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      kill_q  <= kill_d;
    end
  end

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!bus.flush && (count_q != '0)) state_d = h_mis ? EXC : REQ;
      REQ:     if (bus.flush) state_d = IDLE;
               else if (bus.dc_req_ready) state_d = WAIT;
      WAIT:    if (bus.dc_resp_valid) state_d = IDLE;
      EXC:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A flushed request drops in the same cycle so the cache can never grant it.
  always_comb begin
    req_valid = 1'b0;
    wb_valid  = 1'b0;
    wb_exc    = 1'b0;
    case (state_q)
      REQ:  req_valid = !bus.flush;
      WAIT: wb_valid  = bus.dc_resp_valid && !bus.flush && !kill_q;
      EXC: begin
        wb_valid = !bus.flush;
        wb_exc   = !bus.flush;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------- datapath
  always_comb begin
    case (h_size)
      2'd0:    be = 4'b0001 << h_off;
      2'd1:    be = 4'b0011 << h_off;
      default: be = 4'b1111;
    endcase
  end

  always_comb begin
    shifted = bus.dc_resp_rdata >> {h_off, 3'b000};
    case (h_size)
      2'd0:    load_data = h_uns ? {24'h0, shifted[7:0]}
                                 : {{24{shifted[7]}}, shifted[7:0]};
      2'd1:    load_data = h_uns ? {16'h0, shifted[15:0]}
                                 : {{16{shifted[15]}}, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

  assign bus.dc_req_valid = req_valid;
  assign bus.dc_req_addr  = req_valid ? {h_addr[31:2], 2'b00} : '0;
  assign bus.dc_req_we    = req_valid && h_store;
  assign bus.dc_req_be    = req_valid ? be : '0;
  assign bus.dc_req_wdata = req_valid ? (h_wdata << {h_off, 3'b000}) : '0;

  assign bus.wb_valid   = wb_valid;
  assign bus.wb_exc     = wb_exc;
  assign bus.wb_rob_tag = wb_valid ? h_tag : '0;
  assign bus.wb_data    = (wb_valid && !wb_exc && !h_store) ? load_data : '0;

endmodule

// File: tb/tb_lsu_addr_queue.sv
// Directed test of lsu_addr_queue against a transaction-level queue model that is
// checked every cycle, plus hand-computed literal expectations.
module tb_lsu_addr_queue;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lsu_addr_queue_if bus ();

  lsu_addr_queue #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] addr;
    logic        st;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] wdata;
    logic [5:0]  tag;
    logic        issued;
    logic        killed;
  } op_t;

  op_t pending[$];
  int  n_cmp = 0;
  int  n_bad = 0;

  logic        r_req, r_we, r_wb, r_exc;
  logic [31:0] r_addr, r_wdata, r_data;
  logic [3:0]  r_be;
  logic [5:0]  r_tag;
  int          r_lat;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- spec rules
  function automatic logic f_mis(input op_t o);
    int nb;
    if (o.size == 2'd3) return 1'b1;
    nb = 1 << o.size;
    return (int'(o.addr[1:0]) % nb) != 0;
  endfunction

  function automatic logic [3:0] f_be(input op_t o);
    logic [3:0] be;
    int off, nb;
    off = int'(o.addr[1:0]);
    nb  = 1 << o.size;
    be  = '0;
    for (int b = 0; b < 4; b++) be[b] = (b >= off) && (b < off + nb);
    return be;
  endfunction

  function automatic logic [31:0] f_load(input op_t o, input logic [31:0] rd);
    logic [31:0] v;
    int off, nb;
    off = int'(o.addr[1:0]);
    nb  = 1 << o.size;
    v   = '0;
    for (int b = 0; b < nb; b++) v = v | (32'(rd[8*(off+b) +: 8]) << (8*b));
    if (!o.uns && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8*nb));
    return v;
  endfunction

  // ---------------------------------------------------------------- model
  task automatic model_step();
    op_t h, n;
    if (rst) begin
      pending.delete();
      return;
    end
    cmp("agu_ready", 32'(bus.agu_ready), 32'(pending.size() < DEPTH));
    if (!bus.wb_valid) cmp("wb_exc_quiet", 32'(bus.wb_exc), 0);
    if (pending.size() == 0) begin
      cmp("req_valid_empty", 32'(bus.dc_req_valid), 0);
      cmp("wb_valid_empty", 32'(bus.wb_valid), 0);
    end else begin
      h = pending[0];
      if (bus.dc_req_valid) begin
        if (h.issued || f_mis(h)) cmp("req_valid_unexp", 32'(bus.dc_req_valid), 0);
        else begin
          cmp("req_addr", bus.dc_req_addr, {h.addr[31:2], 2'b00});
          cmp("req_be", 32'(bus.dc_req_be), 32'(f_be(h)));
          cmp("req_we", 32'(bus.dc_req_we), 32'(h.st));
          cmp("req_wdata", bus.dc_req_wdata, h.wdata << (8*int'(h.addr[1:0])));
        end
      end
      if (h.issued) begin
        cmp("wb_valid_resp", 32'(bus.wb_valid),
            32'(bus.dc_resp_valid && !bus.flush && !h.killed));
        if (bus.wb_valid) begin
          cmp("wb_tag", 32'(bus.wb_rob_tag), 32'(h.tag));
          cmp("wb_data", bus.wb_data, h.st ? 32'h0 : f_load(h, bus.dc_resp_rdata));
          cmp("wb_exc", 32'(bus.wb_exc), 0);
        end
        if (bus.dc_resp_valid) void'(pending.pop_front());
        else if (bus.flush) begin
          h.killed = 1'b1;
          pending.delete();
          pending.push_back(h);
        end
      end else if (f_mis(h)) begin
        if (bus.flush) cmp("wb_valid_exc_flush", 32'(bus.wb_valid), 0);
        if (bus.wb_valid) begin
          cmp("exc_tag", 32'(bus.wb_rob_tag), 32'(h.tag));
          cmp("exc_data", bus.wb_data, 0);
          cmp("exc_flag", 32'(bus.wb_exc), 1);
          if (!bus.flush) void'(pending.pop_front());
        end
      end else begin
        cmp("wb_valid_early", 32'(bus.wb_valid), 0);
        if (bus.dc_req_valid && bus.dc_req_ready && !bus.flush) begin
          h.issued = 1'b1;
          pending[0] = h;
        end
      end
      if (bus.flush && !(h.issued && !bus.dc_resp_valid)) pending.delete();
    end
    if (bus.agu_valid && bus.agu_ready && !bus.flush) begin
      n.addr = bus.agu_addr;   n.st = bus.agu_is_store; n.size = bus.agu_size;
      n.uns = bus.agu_unsigned; n.wdata = bus.agu_wdata; n.tag = bus.agu_rob_tag;
      n.issued = 1'b0;          n.killed = 1'b0;
      pending.push_back(n);
    end
  endtask

  task automatic half();
    @(negedge clk);
    model_step();
  endtask

  task automatic rise();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [31:0] a, input logic st, input logic [1:0] sz,
                        input logic uns, input logic [31:0] wd, input logic [5:0] tg);
    bus.agu_valid = 1'b1;  bus.agu_addr = a;     bus.agu_is_store = st;
    bus.agu_size = sz;     bus.agu_unsigned = uns;
    bus.agu_wdata = wd;    bus.agu_rob_tag = tg;
  endtask

  task automatic enq(input logic [31:0] a, input logic st, input logic [1:0] sz,
                     input logic uns, input logic [31:0] wd, input logic [5:0] tg);
    set_op(a, st, sz, uns, wd, tg);
    half();
    rise();
  endtask

  // One op through an otherwise idle queue with an always-ready cache that
  // answers one cycle after the grant.
  task automatic do_op(input logic [31:0] a, input logic st, input logic [1:0] sz,
                       input logic uns, input logic [31:0] wd, input logic [5:0] tg,
                       input logic [31:0] rd);
    logic sent;
    enq(a, st, sz, uns, wd, tg);
    bus.agu_valid = 1'b0;
    r_req = 0; r_we = 0; r_wb = 0; r_exc = 0; r_addr = 0; r_wdata = 0;
    r_data = 0; r_be = 0; r_tag = 0; r_lat = 0; sent = 0;
    for (int i = 0; i < 12 && !r_wb; i++) begin
      half();
      if (bus.dc_req_valid && !r_req) begin
        r_req = 1; r_addr = bus.dc_req_addr; r_be = bus.dc_req_be;
        r_we = bus.dc_req_we; r_wdata = bus.dc_req_wdata;
      end
      if (bus.wb_valid) begin
        r_wb = 1; r_tag = bus.wb_rob_tag; r_data = bus.wb_data;
        r_exc = bus.wb_exc; r_lat = i + 1;
      end
      rise();
      if (r_req && !sent && !r_wb) begin
        bus.dc_resp_valid = 1'b1; bus.dc_resp_rdata = rd; sent = 1;
      end else bus.dc_resp_valid = 1'b0;
    end
    bus.dc_resp_valid = 1'b0;
  endtask

  task automatic expect_op(input string t, input logic req, input logic [31:0] addr,
                           input logic [3:0] be, input logic we, input logic [31:0] wdata,
                           input logic [5:0] tag, input logic [31:0] data,
                           input logic exc, input int lat);
    cmp({t, "_req"}, 32'(r_req), 32'(req));
    cmp({t, "_addr"}, r_addr, addr);
    cmp({t, "_be"}, 32'(r_be), 32'(be));
    cmp({t, "_we"}, 32'(r_we), 32'(we));
    cmp({t, "_wdata"}, r_wdata, wdata);
    cmp({t, "_wb"}, 32'(r_wb), 1);
    cmp({t, "_tag"}, 32'(r_tag), 32'(tag));
    cmp({t, "_data"}, r_data, data);
    cmp({t, "_exc"}, 32'(r_exc), 32'(exc));
    cmp({t, "_lat"}, 32'(r_lat), 32'(lat));
  endtask

  logic [5:0] tags [4];
  int         nwb;
  logic       acc;

  initial begin
    bus.agu_valid = 0; bus.agu_addr = 0; bus.agu_is_store = 0; bus.agu_size = 0;
    bus.agu_unsigned = 0; bus.agu_wdata = 0; bus.agu_rob_tag = 0; bus.flush = 0;
    bus.dc_req_ready = 0; bus.dc_resp_valid = 0; bus.dc_resp_rdata = 0;

    half();
    cmp("rst_agu_ready", 32'(bus.agu_ready), 1);
    cmp("rst_req_valid", 32'(bus.dc_req_valid), 0);
    cmp("rst_wb_valid", 32'(bus.wb_valid), 0);
    cmp("rst_wb_exc", 32'(bus.wb_exc), 0);
    cmp("rst_req_addr", bus.dc_req_addr, 0);
    cmp("rst_wb_data", bus.wb_data, 0);
    rise();
    half();
    rise();
    rst = 1'b0;
    bus.dc_req_ready = 1'b1;

    do_op(32'h100, 0, 2'd2, 0, 32'h0, 6'd1, 32'hDEADBEEF);
    expect_op("lw", 1, 32'h100, 4'b1111, 0, 32'h0, 6'd1, 32'hDEADBEEF, 0, 3);
    do_op(32'h103, 0, 2'd0, 0, 32'h0, 6'd2, 32'h80FFFFFF);
    expect_op("lb", 1, 32'h100, 4'b1000, 0, 32'h0, 6'd2, 32'hFFFFFF80, 0, 3);
    do_op(32'h103, 0, 2'd0, 1, 32'h0, 6'd3, 32'h80FFFFFF);
    expect_op("lbu", 1, 32'h100, 4'b1000, 0, 32'h0, 6'd3, 32'h00000080, 0, 3);
    do_op(32'h102, 1, 2'd1, 0, 32'h0000ABCD, 6'd4, 32'h12345678);
    expect_op("sh", 1, 32'h100, 4'b1100, 1, 32'hABCD0000, 6'd4, 32'h0, 0, 3);
    do_op(32'h101, 0, 2'd2, 0, 32'h0, 6'd5, 32'h0);
    expect_op("lw_mis", 0, 32'h0, 4'b0000, 0, 32'h0, 6'd5, 32'h0, 1, 2);
    do_op(32'h100, 0, 2'd3, 0, 32'h0, 6'd6, 32'h0);
    expect_op("sz3", 0, 32'h0, 4'b0000, 0, 32'h0, 6'd6, 32'h0, 1, 2);
    do_op(32'h202, 0, 2'd1, 0, 32'h0, 6'd7, 32'h80011234);
    expect_op("lh", 1, 32'h200, 4'b1100, 0, 32'h0, 6'd7, 32'hFFFF8001, 0, 3);
    do_op(32'h201, 1, 2'd1, 0, 32'h1111, 6'd8, 32'h0);
    expect_op("sh_mis", 0, 32'h0, 4'b0000, 0, 32'h0, 6'd8, 32'h0, 1, 2);
    do_op(32'h301, 1, 2'd0, 0, 32'h000000AB, 6'd9, 32'h0);
    expect_op("sb", 1, 32'h300, 4'b0010, 1, 32'h0000AB00, 6'd9, 32'h0, 0, 3);

    // Fill with the cache stalled, then drain in order.
    bus.dc_req_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      set_op(32'h400 + 32'(4*k), 0, 2'd2, 0, 32'h0, 6'(10 + k));
      half();
      if (k == 4) cmp("fill_ready_full", 32'(bus.agu_ready), 0);
      rise();
    end
    bus.agu_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      half();
      cmp("fill_hold_valid", 32'(bus.dc_req_valid), 1);
      cmp("fill_hold_addr", bus.dc_req_addr, 32'h400);
      rise();
    end
    bus.dc_req_ready = 1'b1;
    nwb = 0;
    for (int i = 0; i < 40 && nwb < 4; i++) begin
      half();
      acc = bus.dc_req_valid && bus.dc_req_ready;
      if (bus.wb_valid) begin
        if (nwb < 4) tags[nwb] = bus.wb_rob_tag;
        nwb++;
      end
      rise();
      bus.dc_resp_valid = acc;
      bus.dc_resp_rdata = 32'hC0DE0000 + 32'(i);
    end
    bus.dc_resp_valid = 1'b0;
    cmp("drain_count", 32'(nwb), 4);
    for (int k = 0; k < 4; k++) cmp("drain_tag", 32'(tags[k]), 32'(10 + k));

    // Flush while the head waits on the cache with two more ops queued.
    enq(32'h500, 0, 2'd2, 0, 32'h0, 6'd20);
    enq(32'h504, 0, 2'd2, 0, 32'h0, 6'd21);
    enq(32'h508, 0, 2'd2, 0, 32'h0, 6'd22);
    bus.agu_valid = 1'b0;
    bus.flush = 1'b1;
    half();
    cmp("fw_wb_on_flush", 32'(bus.wb_valid), 0);
    rise();
    bus.flush = 1'b0;
    bus.dc_resp_valid = 1'b1;
    bus.dc_resp_rdata = 32'h5555AAAA;
    half();
    cmp("fw_wb_suppressed", 32'(bus.wb_valid), 0);
    rise();
    bus.dc_resp_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      half();
      cmp("fw_agu_ready", 32'(bus.agu_ready), 1);
      cmp("fw_queue_empty", 32'(bus.dc_req_valid), 0);
      rise();
    end

    // Flush while a request is raised but not granted.
    bus.dc_req_ready = 1'b0;
    enq(32'h600, 0, 2'd2, 0, 32'h0, 6'd30);
    enq(32'h604, 0, 2'd2, 0, 32'h0, 6'd31);
    bus.agu_valid = 1'b0;
    half();
    cmp("fr_req_up", 32'(bus.dc_req_valid), 1);
    rise();
    bus.flush = 1'b1;
    half();
    cmp("fr_req_drop", 32'(bus.dc_req_valid), 0);
    rise();
    bus.flush = 1'b0;
    for (int k = 0; k < 2; k++) begin
      half();
      cmp("fr_req_gone", 32'(bus.dc_req_valid), 0);
      rise();
    end
    bus.dc_req_ready = 1'b1;

    // Flush during the exception writeback cycle.
    enq(32'h701, 0, 2'd2, 0, 32'h0, 6'd40);
    bus.agu_valid = 1'b0;
    half();
    rise();
    bus.flush = 1'b1;
    half();
    cmp("fe_wb_suppressed", 32'(bus.wb_valid), 0);
    rise();
    bus.flush = 1'b0;
    half();
    cmp("fe_after", 32'(bus.wb_valid), 0);
    rise();

    // A stray response with nothing outstanding.
    bus.dc_resp_valid = 1'b1;
    bus.dc_resp_rdata = 32'h12345678;
    half();
    cmp("stray_resp", 32'(bus.wb_valid), 0);
    rise();
    bus.dc_resp_valid = 1'b0;

    // Reset while waiting on the cache; the late response must be ignored.
    enq(32'h800, 0, 2'd2, 0, 32'h0, 6'd50);
    bus.agu_valid = 1'b0;
    half();
    rise();
    half();
    rise();
    rst = 1'b1;
    half();
    cmp("mrst_wb", 32'(bus.wb_valid), 0);
    cmp("mrst_ready", 32'(bus.agu_ready), 1);
    cmp("mrst_req", 32'(bus.dc_req_valid), 0);
    rise();
    rst = 1'b0;
    bus.dc_resp_valid = 1'b1;
    bus.dc_resp_rdata = 32'hFFFFFFFF;
    half();
    cmp("mrst_resp_ignored", 32'(bus.wb_valid), 0);
    rise();
    bus.dc_resp_valid = 1'b0;

    do_op(32'h902, 0, 2'd0, 0, 32'h0, 6'd60, 32'h00AB0000);
    expect_op("lb_after_rst", 1, 32'h900, 4'b0100, 0, 32'h0, 6'd60, 32'hFFFFFFAB, 0, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
